// File: rtl/element_collector_pkg.sv
// ---------------------------------------------------------------------------
// element_collector_pkg
// Shared constants for the element collection pipeline: default element
// width, elements per output vector, fill-count width helper and the
// collector FSM state encoding.
// ---------------------------------------------------------------------------
package element_collector_pkg;

   localparam int ELEMENT_WIDTH  = 64;
   localparam int NO_OF_ELEMENTS = 8;

   // Count width must represent 0..n inclusive (a full vector reports n).
   function automatic int count_width(input int n);
      return $clog2(n) + 1;
   endfunction

   localparam int COUNT_WIDTH = count_width(NO_OF_ELEMENTS);

   // Collector FSM encoding
   localparam logic [0:0] ST_COLLECT = 1'b0;  // accepting elements
   localparam logic [0:0] ST_HOLD    = 1'b1;  // collect buffer holds a finished vector

endpackage

// File: rtl/element_collector.sv
// ---------------------------------------------------------------------------
// element_collector
// Packs a stream of elements into vectors of no_of_elements lanes and hands
// each vector to a single-entry output register.
//
// Handshake: a vector is transferred downstream on every rising clk edge
// where out_valid && out_ready; out_data/out_count stay stable while
// out_valid && !out_ready. in_valid has no back-pressure: an element that
// arrives while the collect buffer is occupied by a waiting vector (HOLD) is
// dropped and the sticky overflow flag is raised.
//
// Ports:
//   clk          sole clock
//   rst          asynchronous active-high reset
//   in_valid     in_data carries an element this cycle
//   in_data      element (element_width bits)
//   flush        emit the partially filled vector
//   out_ready    downstream accepts out_data this cycle
//   out_valid    out_data/out_count hold a vector
//   out_data     packed vector, lane k at [k*element_width +: element_width]
//   out_count    number of filled lanes in out_data
//   overflow     sticky: an element was dropped
//   o_dbg_state  current collector FSM state (ST_COLLECT / ST_HOLD)
// ---------------------------------------------------------------------------
module element_collector
   import element_collector_pkg::*;
#(
   parameter int element_width  = ELEMENT_WIDTH,
   parameter int no_of_elements = NO_OF_ELEMENTS,
   localparam int CW = count_width(no_of_elements),
   localparam int VW = element_width * no_of_elements
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [element_width-1:0] in_data,
   input  logic                     flush,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [VW-1:0]            out_data,
   output logic [CW-1:0]            out_count,
   output logic                     overflow,
   output logic [0:0]               o_dbg_state
);

   logic [0:0]    r_state;
   logic [CW-1:0] r_fill_cnt;
   logic [VW-1:0] r_buf;
   logic [CW-1:0] r_hold_cnt;
   logic [VW-1:0] r_out_data;
   logic [CW-1:0] r_out_count;
   logic          r_out_valid;
   logic          r_overflow;

   logic          w_collect;
   logic          w_drain;
   logic          w_out_free;
   logic          w_accept;
   logic [CW-1:0] w_new_cnt;
   logic          w_complete;
   logic          w_flush_emit;
   logic          w_emit;
   logic [VW-1:0] w_buf_next;

   always_comb begin
      w_collect    = (r_state == ST_COLLECT);
      w_drain      = r_out_valid && out_ready;
      // Output register can take a vector this edge if empty or draining.
      w_out_free   = !r_out_valid || out_ready;
      w_accept     = w_collect && in_valid;
      w_new_cnt    = r_fill_cnt + {{(CW-1){1'b0}}, w_accept};
      w_complete   = w_accept && (w_new_cnt == CW'(no_of_elements));
      // Flush includes a coincident element; an empty buffer ignores flush.
      w_flush_emit = w_collect && flush && (w_new_cnt != '0);
      w_emit       = w_complete || w_flush_emit;

      // A new vector starts from an all-zero buffer so partial vectors never
      // expose stale lanes.
      w_buf_next = (r_fill_cnt == '0) ? '0 : r_buf;
      for (int k = 0; k < no_of_elements; k++) begin
         if (w_accept && (r_fill_cnt == CW'(k))) begin
            w_buf_next[k*element_width +: element_width] = in_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_COLLECT;
         r_fill_cnt  <= '0;
         r_buf       <= '0;
         r_hold_cnt  <= '0;
         r_out_data  <= '0;
         r_out_count <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         // Anything arriving in HOLD (including the drain edge) is lost.
         if (in_valid && !w_collect) begin
            r_overflow <= 1'b1;
         end

         // Drained output goes empty unless a transfer below refills it.
         if (w_drain) begin
            r_out_valid <= 1'b0;
         end

         if (w_collect) begin
            if (w_emit) begin
               r_fill_cnt <= '0;
               if (w_out_free) begin
                  r_out_data  <= w_buf_next;
                  r_out_count <= w_new_cnt;
                  r_out_valid <= 1'b1;
                  r_buf       <= '0;
               end else begin
                  r_buf      <= w_buf_next;
                  r_hold_cnt <= w_new_cnt;
                  r_state    <= ST_HOLD;
               end
            end else begin
               r_buf      <= w_buf_next;
               r_fill_cnt <= w_new_cnt;
            end
         end else if (w_drain) begin
            r_out_data  <= r_buf;
            r_out_count <= r_hold_cnt;
            r_out_valid <= 1'b1;
            r_buf       <= '0;
            r_state     <= ST_COLLECT;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_count   = r_out_count;
   assign overflow    = r_overflow;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_element_collector.sv
// ---------------------------------------------------------------------------
// tb_element_collector
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a queue-based model.
// ---------------------------------------------------------------------------
module tb_element_collector;
   import element_collector_pkg::*;

   localparam int EW = ELEMENT_WIDTH;
   localparam int N  = NO_OF_ELEMENTS;
   localparam int CW = COUNT_WIDTH;
   localparam int VW = EW * N;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [EW-1:0] in_data;
   logic          flush;
   logic          out_ready;
   logic          out_valid;
   logic [VW-1:0] out_data;
   logic [CW-1:0] out_count;
   logic          overflow;
   logic [0:0]    dbg_state;

   always #5 clk = ~clk;

   element_collector dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .flush       (flush),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_count   (out_count),
      .overflow    (overflow),
      .o_dbg_state (dbg_state)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] lane(input logic [VW-1:0] v, input int k);
      return v[k*EW +: EW];
   endfunction

   // ---------------- behavioural model ----------------
   // Pending vectors in delivery order: entry 0 is the output register, a
   // second entry is a finished vector waiting in the collect buffer.
   logic [EW-1:0] m_cur_q[$];
   logic [VW-1:0] exp_q[$];
   logic [CW-1:0] exp_cnt_q[$];
   bit            m_ovf;
   int            m_sz;
   bit            m_built;
   logic [VW-1:0] m_vec;
   logic [CW-1:0] m_vcnt;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_cur_q.delete();
            exp_q.delete();
            exp_cnt_q.delete();
            m_ovf = 1'b0;
         end else begin
            m_sz    = exp_q.size();
            m_built = 1'b0;
            if (m_sz == 2) begin
               if (in_valid) m_ovf = 1'b1;
            end else begin
               if (in_valid) m_cur_q.push_back(in_data);
               if (m_cur_q.size() == N || (flush && m_cur_q.size() != 0)) begin
                  m_vec = '0;
                  foreach (m_cur_q[i]) m_vec[i*EW +: EW] = m_cur_q[i];
                  m_vcnt = CW'(m_cur_q.size());
                  m_cur_q.delete();
                  m_built = 1'b1;
               end
            end
            if (m_sz > 0 && out_ready) begin
               void'(exp_q.pop_front());
               void'(exp_cnt_q.pop_front());
            end
            if (m_built) begin
               exp_q.push_back(m_vec);
               exp_cnt_q.push_back(m_vcnt);
            end
         end
      end
   end

   // ---------------- compare process ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("out_valid", VW'(out_valid), VW'(exp_q.size() != 0));
            check("overflow", VW'(overflow), VW'(m_ovf));
            check("hold_state", VW'(dbg_state == ST_HOLD), VW'(exp_q.size() == 2));
            if (exp_q.size() != 0) begin
               check("out_data", out_data, exp_q[0]);
               check("out_count", VW'(out_count), VW'(exp_cnt_q[0]));
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Inputs change 1 time unit after a rising edge; returns 1 unit after the
   // next rising edge, so outputs reflect the edge that sampled the inputs.
   task automatic step(input bit iv, input logic [EW-1:0] id, input bit fl, input bit ord, input bit rs);
      in_valid  = iv;
      in_data   = id;
      flush     = fl;
      out_ready = ord;
      rst       = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, '0, 1'b0, 1'b1, 1'b1);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1'b1;

      // Reset state
      check("rst_out_valid", VW'(out_valid), '0);
      check("rst_out_data", out_data, '0);
      check("rst_out_count", VW'(out_count), '0);
      check("rst_overflow", VW'(overflow), '0);
      rst = 1'b0;

      // Flush with empty buffer is ignored
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("empty_flush_valid", VW'(out_valid), '0);

      // Eight elements 1..8
      for (int i = 1; i <= 8; i++) step(1'b1, EW'(i), 1'b0, 1'b1, 1'b0);
      check("v8_valid", VW'(out_valid), VW'(1));
      check("v8_lane0", VW'(lane(out_data, 0)), VW'(1));
      check("v8_lane7", VW'(lane(out_data, 7)), VW'(8));
      check("v8_count", VW'(out_count), VW'(8));
      check("v8_overflow", VW'(overflow), '0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Sixteen back-to-back elements
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, EW'(i), 1'b0, 1'b1, 1'b0);
         if (i == 8)  check("b2b_first_lane0", VW'(lane(out_data, 0)), VW'(1));
         if (i == 16) check("b2b_second_lane0", VW'(lane(out_data, 0)), VW'(9));
      end
      check("b2b_overflow", VW'(overflow), '0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Back-pressure: 17 elements with out_ready low
      for (int i = 1; i <= 17; i++) step(1'b1, EW'(i), 1'b0, 1'b0, 1'b0);
      check("bp_lane0", VW'(lane(out_data, 0)), VW'(1));
      check("bp_lane7", VW'(lane(out_data, 7)), VW'(8));
      check("bp_overflow", VW'(overflow), VW'(1));
      check("bp_hold", VW'(dbg_state), VW'(ST_HOLD));
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("bp_second_lane0", VW'(lane(out_data, 0)), VW'(9));
      check("bp_second_lane7", VW'(lane(out_data, 7)), VW'(16));
      check("bp_second_valid", VW'(out_valid), VW'(1));
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("bp_drained_valid", VW'(out_valid), '0);
      check("bp_overflow_sticky", VW'(overflow), VW'(1));

      // Partial vector via flush
      do_reset();
      for (int i = 5; i <= 7; i++) step(1'b1, EW'(i), 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("flush_count", VW'(out_count), VW'(3));
      check("flush_lane0", VW'(lane(out_data, 0)), VW'(5));
      check("flush_lane2", VW'(lane(out_data, 2)), VW'(7));
      check("flush_upper_zero", out_data >> (3 * EW), '0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Reset mid-vector discards partial data
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, EW'(100 + i), 1'b0, 1'b1, 1'b0);
      do_reset();
      for (int i = 20; i <= 27; i++) step(1'b1, EW'(i), 1'b0, 1'b1, 1'b0);
      check("rst_mid_lane0", VW'(lane(out_data, 0)), VW'(20));
      check("rst_mid_lane7", VW'(lane(out_data, 7)), VW'(27));
      check("rst_mid_count", VW'(out_count), VW'(8));
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 9) < 7,
              {$urandom, $urandom},
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) < 6,
              $urandom_range(0, 499) == 0);
      end
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/element_collector.md
ELEMENT_COLLECTOR -- requirements
Module: element_collector

Interface
REQ-001 SHALL have parameter element_width, default 64, meaning bit width of one data element.
REQ-002 SHALL have parameter no_of_elements, default 8, meaning elements packed per output vector.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  in_data carries a valid element this cycle; travels beside the element through the upstream 4-cycle delay.
REQ-006 SHALL have port in_data  input  element_width  element from the upstream delay stage.
REQ-007 SHALL have port flush  input  1  emit the partially filled vector.
REQ-008 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data/out_count hold a vector.
REQ-010 SHALL have port out_data  output  element_width*no_of_elements  packed vector; lane k at bits [k*element_width +: element_width].
REQ-011 SHALL have port out_count  output  clog2(no_of_elements)+1  number of filled lanes in out_data.
REQ-012 SHALL have port overflow  output  1  sticky flag: an element was dropped.

Function
REQ-013 SHALL write each accepted element into collect-buffer lane fill_cnt, then increment fill_cnt; first element of a vector goes to lane 0.
REQ-014 SHALL complete a vector when the element landing in lane no_of_elements-1 is accepted; fill_cnt then returns to 0.
REQ-015 SHALL transfer a completed vector to the output register on that same edge if the output register is empty or drained that cycle (out_valid&&out_ready); out_valid rises the following cycle (latency 1 from last element edge).
REQ-016 SHALL, when the output register is occupied and not draining, hold the completed vector in the collect buffer (state HOLD) and transfer it on the edge where out_valid&&out_ready.
REQ-017 SHALL implement states COLLECT (accepting) and HOLD (collect buffer full); COLLECT->HOLD on REQ-016 condition, HOLD->COLLECT on drain edge.
REQ-018 SHALL in HOLD drop any in_valid element and set overflow; it SHALL remain set until rst. In_valid on the drain edge itself SHALL also be dropped.
REQ-019 SHALL hold out_data/out_count stable while out_valid&&!out_ready; clear out_valid after a drain edge with no new transfer.
REQ-020 SHALL on flush with fill_cnt>0 (COLLECT) transfer the partial vector per REQ-015/016 rules, out_count=fill_cnt, unfilled lanes zero.
REQ-021 SHALL on flush coincident with in_valid include that element first (out_count=fill_cnt+1); if this fills lane no_of_elements-1, treat as normal completion.
REQ-022 SHALL ignore flush when fill_cnt==0 and !in_valid, or in HOLD.
REQ-023 SHALL zero collect-buffer lanes when a new vector starts, so partial vectors never carry stale data.
REQ-024 SHALL sustain one element per cycle with out_ready=1 continuously, no drops.

Reset
REQ-025 SHALL on rst asynchronously clear out_valid=0, out_data=0, out_count=0, overflow=0, fill_cnt=0, collect buffer=0, state=COLLECT.
REQ-026 SHALL discard any partial or held vector when rst asserts mid-operation; first element after rst release lands in lane 0.

Structure
REQ-027 SHALL take element_width, no_of_elements, count width and state encoding from a shared package used by all pipeline stages.
REQ-028 SHALL be a single module; no sub-module (upstream delay is instantiated by the parent, not here).

Verification
REQ-029 SHALL cover: 8 consecutive in_valid elements 1..8, out_ready=1 -> out_valid one cycle after 8th, lane0=1, lane7=8, out_count=8, overflow=0.
REQ-030 SHALL cover: 16 back-to-back elements 1..16, out_ready=1 -> two vectors (1..8, 9..16) on consecutive-eligible cycles, no drops.
REQ-031 SHALL cover: out_ready=0, 17 elements -> vector 1..8 held on output, 9..16 in HOLD, element 17 dropped, overflow=1; out_ready=1 -> 1..8 then 9..16 delivered.
REQ-032 SHALL cover: elements 5,6,7 then flush -> out_count=3, lanes 0..2=5,6,7, lanes 3..7=0.
REQ-033 SHALL cover: rst pulse after 4 elements, then 8 elements 20..27 -> single vector lane0=20, out_count=8, no trace of earlier data.
